lsu_arb: RTL and testbench
==========================

Name: lsu_arb

Overview:
- Two-requester arbiter in front of the single-port load/store unit. Shares it between the core data port (m0) and a DMA/debug master (m1).
- Round-robin grant; one LSU access issued per cycle. LSU read data is registered inside the LSU, so the arbiter tracks the owner of each read and routes the returned data one cycle later.
- Sits between the core/DMA masters and the LSU.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- INIT_PRIO, 0, requester holding priority after reset (0 = m0, 1 = m1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_m0_req  in  1  m0 access request; held with attributes until granted
- i_m0_wren  in  1  m0 write enable (1 = store, 0 = load)
- i_m0_addr  in  AW  m0 byte address
- i_m0_wdata  in  DW  m0 store data
- o_m0_gnt  out  1  m0 access issued this cycle
- o_m0_rvalid  out  1  m0 load data valid
- o_m0_rdata  out  DW  m0 load data
- i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as m0, for m1
- i_m0_lock  in  1  m0 bus-lock request (present only with LSU_ARB_LOCK_EN)
- o_lsu_wren  out  1  to LSU write enable
- o_lsu_addr  out  AW  to LSU address
- o_st_data  out  DW  to LSU store data
- i_ld_data  in  DW  from LSU registered load data

Behaviour:
- Arbitration is combinational from the requests and the registered priority pointer (prio).
  - Only one requester asserts req: that requester wins.
  - Both assert req: the requester named by prio wins.
- o_mX_gnt is high in the cycle the access is presented on the LSU port. The LSU samples it at the next rising edge.
- Requester handshake:
  - Hold req, wren, addr and wdata stable until gnt is seen.
  - Deassert req, or present a new access, in the cycle after gnt.
- Pointer update: after any grant, prio <= the non-winner. With no grant, prio holds.
- Writes:
  - Complete at the edge following gnt.
  - Produce no rvalid.
- Reads:
  - Latency is 1: the edge after the read gnt sets o_mX_rvalid for exactly one cycle.
  - o_mX_rdata = i_ld_data, passthrough, qualified by rvalid.
  - rd_owner and rd_pending registers record which requester gets the data.
- Back-to-back: a read can be granted in the same cycle the previous read's rvalid is high. Full throughput is one access per cycle.
- Idle (no grant):
  - o_lsu_wren = 0.
  - o_lsu_addr and o_st_data hold their last issued values, held in registers. This prevents a stray write and keeps the LSU read target stable.
- When no requester wins, o_lsu_wren must be 0. This overrides any stale wren.
- Reset (async, i_rst = 0):
  - prio = INIT_PRIO.
  - rd_pending = 0, so both rvalid = 0.
  - Held address = 0, held store data = 0.
  - Lock state cleared.
- Reset during an outstanding read: the read data is discarded and no rvalid follows.
- Non-grant outputs: gnt = 0, rvalid = 0, rdata is don't-care when rvalid = 0.

Optional Feature:
- Macro LSU_ARB_LOCK_EN.
- Defined:
  - The i_m0_lock port exists.
  - FSM states: ARB, LOCK0.
  - ARB -> LOCK0: on an m0 grant while i_m0_lock = 1.
  - In LOCK0, only m0 can win; m1 waits with gnt = 0.
  - LOCK0 -> ARB: on the first m0 grant with i_m0_lock = 0, or when m0 has req = 0 and lock = 0.
  - prio does not change while in LOCK0. On exit, prio = 1.
  - Async reset returns the FSM to ARB.
- Undefined:
  - The port is absent and there is no LOCK0 state.
  - Pure round-robin.

Decomposition:
- Shared package lsu_arb_pkg:
  - Requester id typedef (REQ_M0 = 0, REQ_M1 = 1).
  - Lock FSM state enum.
  - LSU address map constants: DMEM_BASE = 0x2000, LEDR_BASE = 0x7000, LEDG_BASE = 0x7010, HEX_BASE = 0x7020, LCD_BASE = 0x7030, SW_BASE = 0x7800, for bench use.
- One sub-module, lsu_arb_rr2: a 2-way round-robin picker (req[1:0], prio -> onehot grant), combinational.

Test Plan:
- Single requester: m0 stores 0xDEADBEEF to 0x2000, then loads 0x2000.
  - Required: gnt in the request cycle for both accesses.
  - Required: o_m0_rvalid exactly one cycle after the load gnt, with rdata = 0xDEADBEEF.
- Contention from reset (INIT_PRIO = 0): m0 and m1 both request continuous loads.
  - Required: grants alternate m0, m1, m0, m1.
  - Required: each rvalid goes to the correct requester, with no cross-routing.
- Back-to-back reads: m1 issues loads from 0x2004 and 0x2008 on consecutive cycles.
  - Required: two consecutive rvalid pulses with data in order.
- Idle after store: m1 stores 0x5 to 0x7000, then no requests.
  - Required: o_lsu_wren = 0 in the following cycles.
  - Required: o_lsu_addr holds 0x7000.
  - Required: LEDR stays 0x5.
- Reset mid-read: assert i_rst = 0 asynchronously right after an m0 load gnt.
  - Required: no rvalid.
  - Required: prio returns to INIT_PRIO.
  - Required: all gnt = 0 while reset is held.
- LSU_ARB_LOCK_EN: m0 issues lock + load, then lock + store, with m1 requesting throughout.
  - Required: m1 gnt stays 0 until m0's unlocked access is granted.
  - Required: m1 is granted in the next cycle.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types and constants for the LSU arbiter.
//   req_id_e     : requester id (REQ_M0 = core data port, REQ_M1 = DMA/debug)
//   lock_state_e : bus-lock FSM states (used only with LSU_ARB_LOCK_EN)
//   *_BASE       : LSU address map, for bench use
package lsu_arb_pkg;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK0 = 1'b1
    } lock_state_e;

    localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
    localparam logic [31:0] LEDR_BASE = 32'h0000_7000;
    localparam logic [31:0] LEDG_BASE = 32'h0000_7010;
    localparam logic [31:0] HEX_BASE  = 32'h0000_7020;
    localparam logic [31:0] LCD_BASE  = 32'h0000_7030;
    localparam logic [31:0] SW_BASE   = 32'h0000_7800;

endpackage

// File: rtl/lsu_arb_rr2.sv
// lsu_arb_rr2: 2-way round-robin picker, purely combinational.
//   req  [1:0] : request vector (bit 0 = m0, bit 1 = m1)
//   prio       : requester that wins a tie (0 = m0, 1 = m1)
//   gnt  [1:0] : one-hot grant, zero when nobody requests
module lsu_arb_rr2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) gnt = prio ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/lsu_arb.sv
// lsu_arb: shares the single-port LSU between the core data port (m0) and
// a DMA/debug master (m1). One access per cycle, round-robin on contention.
// Loads return one cycle after their grant; the owner of each load is
// remembered so the registered LSU data is steered to the right master.
//   i_clk, i_rst (async, active-low)
//   i_mX_req/wren/addr/wdata, o_mX_gnt, o_mX_rvalid, o_mX_rdata : masters
//   i_m0_lock            : m0 bus lock (only with LSU_ARB_LOCK_EN defined)
//   o_lsu_wren/addr, o_st_data, i_ld_data                  : LSU side
// Optional feature macro: LSU_ARB_LOCK_EN (m0 bus lock, LOCK0 state).
module lsu_arb
    import lsu_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int INIT_PRIO = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_m0_req,
    input  logic          i_m0_wren,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_wren,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,
`ifdef LSU_ARB_LOCK_EN
    input  logic          i_m0_lock,
`endif
    output logic          o_lsu_wren,
    output logic [AW-1:0] o_lsu_addr,
    output logic [DW-1:0] o_st_data,
    input  logic [DW-1:0] i_ld_data
);

    logic [1:0]         req, wren, gnt;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;
    logic               prio, prio_nxt, win, m1_block, rd_pending;
    req_id_e            wsel, rd_owner;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;

    // Requests are masked while reset is held so no grant leaks out.
    assign req   = {i_m1_req & ~m1_block, i_m0_req} & {2{i_rst}};
    assign wren  = {i_m1_wren, i_m0_wren};
    assign addr  = {i_m1_addr, i_m0_addr};
    assign wdata = {i_m1_wdata, i_m0_wdata};

    lsu_arb_rr2 u_rr2 (
        .req  (req),
        .prio (prio),
        .gnt  (gnt)
    );

    assign win  = |gnt;
    assign wsel = gnt[1] ? REQ_M1 : REQ_M0;

    assign o_m0_gnt = gnt[0];
    assign o_m1_gnt = gnt[1];

    // Idle cycles replay the last address/data with write strobe low, so
    // the LSU never sees a stray store and its read target stays put.
    assign o_lsu_wren = win & wren[wsel];
    assign o_lsu_addr = win ? addr[wsel]  : addr_q;
    assign o_st_data  = win ? wdata[wsel] : wdata_q;

    assign o_m0_rvalid = rd_pending & (rd_owner == REQ_M0);
    assign o_m1_rvalid = rd_pending & (rd_owner == REQ_M1);
    assign o_m0_rdata  = i_ld_data;
    assign o_m1_rdata  = i_ld_data;

`ifdef LSU_ARB_LOCK_EN
    lock_state_e state, state_nxt;

    assign m1_block = (state == LOCK0);

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (gnt[0] && i_m0_lock) state_nxt = LOCK0;
            LOCK0:   if (!i_m0_lock && (gnt[0] || !i_m0_req)) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Pointer is frozen while locked; leaving the lock hands priority to m1.
    always_comb begin
        prio_nxt = prio;
        if (state == LOCK0) begin
            if (state_nxt == ARB) prio_nxt = 1'b1;
        end else if (win) begin
            prio_nxt = gnt[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ARB;
        else        state <= state_nxt;
    end
`else
    assign m1_block = 1'b0;

    // After a grant the loser gets priority: m0 won -> prio = 1.
    always_comb begin
        prio_nxt = prio;
        if (win) prio_nxt = gnt[0];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            prio       <= 1'(INIT_PRIO);
            rd_pending <= 1'b0;
            rd_owner   <= REQ_M0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            prio       <= prio_nxt;
            rd_pending <= win & ~o_lsu_wren;
            if (win) begin
                rd_owner <= wsel;
                addr_q   <= addr[wsel];
                wdata_q  <= wdata[wsel];
            end
        end
    end

endmodule

// File: tb/tb_lsu_arb.sv
module tb_lsu_arb;
    import lsu_arb_pkg::*;

    localparam logic [31:0] PAT = 32'hC0DE_0000;  // unwritten LSU words read addr ^ PAT

    logic        i_clk, i_rst;
    logic        m0_req, m0_wren, m1_req, m1_wren;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        lsu_wren;
    logic [31:0] lsu_addr, st_data, ld_data;
`ifdef LSU_ARB_LOCK_EN
    logic        m0_lock;
`endif

    lsu_arb #(.AW(32), .DW(32), .INIT_PRIO(0)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
`ifdef LSU_ARB_LOCK_EN
        .i_m0_lock(m0_lock),
`endif
        .o_lsu_wren(lsu_wren), .o_lsu_addr(lsu_addr), .o_st_data(st_data), .i_ld_data(ld_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // LSU model: registered read-first memory, 64 words hashed from address.
    logic [31:0] mem [64];
    logic [63:0] written;
    logic        mem_clr;
    wire  [5:0]  k = {lsu_addr[14], lsu_addr[6:2]};

    always @(posedge i_clk) begin
        ld_data <= written[k] ? mem[k] : (lsu_addr ^ PAT);
        if (lsu_wren) begin
            mem[k]     <= st_data;
            written[k] <= 1'b1;
        end
        if (mem_clr) written <= '0;
    end

    function automatic logic [31:0] memrd(input logic [31:0] a);
        logic [5:0] j;
        j = {a[14], a[6:2]};
        return written[j] ? mem[j] : (a ^ PAT);
    endfunction

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    typedef struct {
        logic        r0, w0; logic [31:0] a0, d0;
        logic        r1, w1; logic [31:0] a1, d1;
        logic        g0, g1, wr; logic [31:0] ad, st;
        logic        v0, v1; logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, w0, input logic [31:0] a0, d0,
        input logic r1, w1, input logic [31:0] a1, d1,
        input logic g0, g1, wr, input logic [31:0] ad, st,
        input logic v0, v1, input logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.wr = wr; v.ad = ad; v.st = st;
        v.v0 = v0; v.v1 = v1; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                         input logic r1, w1, input logic [31:0] a1, d1);
        m0_req = r0; m0_wren = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_wren = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic chk_cyc(input string t, input logic g0, g1, v0, v1);
        chk({t, "_g0"}, 32'(m0_gnt), 32'(g0));
        chk({t, "_g1"}, 32'(m1_gnt), 32'(g1));
        chk({t, "_rv0"}, 32'(m0_rvalid), 32'(v0));
        chk({t, "_rv1"}, 32'(m1_rvalid), 32'(v1));
    endtask

    vec_t vt[15];

    initial begin
        // rows: m0 {req,wren,addr,wdata}, m1 {...} | gnt0,gnt1,wren,addr,st | rv0,rv1,rdata
        vt[0]  = mk(1,0,32'h2010,0, 1,0,32'h2020,0,  1,0,0,32'h2010,0, 0,0,0);
        vt[1]  = mk(1,0,32'h2010,0, 1,0,32'h2020,0,  0,1,0,32'h2020,0, 1,0,32'hC0DE2010);
        vt[2]  = mk(1,0,32'h2010,0, 1,0,32'h2020,0,  1,0,0,32'h2010,0, 0,1,32'hC0DE2020);
        vt[3]  = mk(1,0,32'h2010,0, 1,0,32'h2020,0,  0,1,0,32'h2020,0, 1,0,32'hC0DE2010);
        vt[4]  = mk(0,0,0,0,        0,0,0,0,         0,0,0,32'h2020,0, 0,1,32'hC0DE2020);
        vt[5]  = mk(1,1,DMEM_BASE,32'hDEADBEEF, 0,0,0,0, 1,0,1,32'h2000,32'hDEADBEEF, 0,0,0);
        vt[6]  = mk(1,0,DMEM_BASE,0, 0,0,0,0,        1,0,0,32'h2000,0, 0,0,0);
        vt[7]  = mk(0,0,0,0,        1,0,32'h2004,0,  0,1,0,32'h2004,0, 1,0,32'hDEADBEEF);
        vt[8]  = mk(0,0,0,0,        1,0,32'h2008,0,  0,1,0,32'h2008,0, 0,1,32'hC0DE2004);
        vt[9]  = mk(0,0,0,0,        1,1,LEDR_BASE,5, 0,1,1,32'h7000,5, 0,1,32'hC0DE2008);
        vt[10] = mk(0,0,0,0,        0,0,0,0,         0,0,0,32'h7000,5, 0,0,0);
        vt[11] = mk(0,0,0,0,        0,0,0,0,         0,0,0,32'h7000,5, 0,0,0);
        vt[12] = mk(1,1,32'h2040,1, 1,1,32'h2044,2,  1,0,1,32'h2040,1, 0,0,0);
        vt[13] = mk(0,0,0,0,        1,1,32'h2044,2,  0,1,1,32'h2044,2, 0,0,0);
        vt[14] = mk(0,0,0,0,        0,0,0,0,         0,0,0,32'h2044,2, 0,0,0);

        mem_clr = 1'b1;
        i_rst   = 1'b0;
`ifdef LSU_ARB_LOCK_EN
        m0_lock = 1'b0;
`endif
        drive(0,0,0,0, 0,0,0,0);
        repeat (2) @(posedge i_clk);
        #4;
        chk_cyc("reset", 0, 0, 0, 0);
        chk("reset_wren", 32'(lsu_wren), 0);
        chk("reset_addr", lsu_addr, 0);
        chk("reset_st", st_data, 0);
        @(posedge i_clk); #1;
        i_rst   = 1'b1;
        mem_clr = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(posedge i_clk); #1;
            drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
            #3;
            chk_cyc($sformatf("v%0d", i), vt[i].g0, vt[i].g1, vt[i].v0, vt[i].v1);
            chk($sformatf("v%0d_wren", i), 32'(lsu_wren), 32'(vt[i].wr));
            chk($sformatf("v%0d_addr", i), lsu_addr, vt[i].ad);
            chk($sformatf("v%0d_st", i), st_data, vt[i].st);
            if (vt[i].v0) chk($sformatf("v%0d_rdata0", i), m0_rdata, vt[i].rd);
            if (vt[i].v1) chk($sformatf("v%0d_rdata1", i), m1_rdata, vt[i].rd);
        end
        chk("ledr", memrd(LEDR_BASE), 32'h5);
        chk("dmem_2040", memrd(32'h2040), 32'h1);
        chk("dmem_2044", memrd(32'h2044), 32'h2);

        // Reset right after an m0 load grant: data dropped, prio back to m0.
        @(posedge i_clk); #1;
        drive(1,0,32'h2010,0, 0,0,0,0);
        #3;
        chk_cyc("prerst", 1, 0, 0, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drive(1,0,32'h2010,0, 1,0,32'h2020,0);
        #3;
        chk_cyc("inrst0", 0, 0, 0, 0);
        @(posedge i_clk); #4;
        chk_cyc("inrst1", 0, 0, 0, 0);
        chk("inrst_wren", 32'(lsu_wren), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #3;
        chk_cyc("postrst", 1, 0, 0, 0);
        @(posedge i_clk); #1;
        drive(0,0,0,0, 1,0,32'h2020,0);
        #3;
        chk_cyc("postrst1", 0, 1, 1, 0);
        chk("postrst1_rd", m0_rdata, 32'hC0DE2010);
        @(posedge i_clk); #1;
        drive(0,0,0,0, 0,0,0,0);
        #3;
        chk_cyc("postrst2", 0, 0, 0, 1);
        chk("postrst2_rd", m1_rdata, 32'hC0DE2020);

`ifdef LSU_ARB_LOCK_EN
        // prio = m0 here; m1 requests throughout the locked sequence.
        @(posedge i_clk); #1;
        m0_lock = 1'b1;
        drive(1,0,32'h2010,0, 1,0,32'h2020,0);
        #3;
        chk_cyc("lockA", 1, 0, 0, 0);
        @(posedge i_clk); #1;
        drive(1,1,32'h2000,32'h77, 1,0,32'h2020,0);
        #3;
        chk_cyc("lockB", 1, 0, 1, 0);
        chk("lockB_wren", 32'(lsu_wren), 1);
        @(posedge i_clk); #1;
        m0_lock = 1'b0;
        drive(1,0,32'h2000,0, 1,0,32'h2020,0);
        #3;
        chk_cyc("lockC", 1, 0, 0, 0);
        @(posedge i_clk); #1;
        drive(0,0,0,0, 1,0,32'h2020,0);
        #3;
        chk_cyc("lockD", 0, 1, 1, 0);
        chk("lockD_rd", m0_rdata, 32'h77);
        @(posedge i_clk); #1;
        drive(0,0,0,0, 0,0,0,0);
`endif

        repeat (2) @(posedge i_clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
